// File: rtl/cipher_round_seq.sv
// Iterative block-cipher sequencer: whitens, runs NROUNDS passes of an external round unit, unwhitens.
// Latency: NROUNDS cycles from accept edge to out_valid; one block in flight at a time.
// Backpressure: result held in OUT until out_ready; a new block can be accepted on the same handshake edge.
module cipher_round_seq #(
  parameter int NROUNDS = 8,
  parameter int RK_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_data,
  input  logic [255:0]    in_key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_data,
  input  logic            flush,
  output logic            busy,
  output logic [63:0]     rnd_idata,
  output logic [RK_W-1:0] rnd_key,
  input  logic [63:0]     rnd_odata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    OUT   = 2'd2
  } fsm_e;

  localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);

  fsm_e        fsm_q, fsm_d;
  logic [3:0]  rnd_cnt_q, rnd_cnt_d;
  logic [63:0] state_q, state_d;
  logic [255:0] key_q, key_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;

  logic        accept;
  logic [63:0] in_x;
  logic [63:0] in_white;
  logic [63:0] out_white;
  logic [7:0]  key_shamt;
  logic [7:0]  key_msb;

  // Ready is suppressed during reset and flush so nothing can slip in alongside an abort.
  assign in_ready = ~rst & ~flush &
                    ((fsm_q == IDLE) | ((fsm_q == OUT) & out_ready));
  assign accept   = in_valid & in_ready;

  // Input whitening with the middle key quarter, then a Feistel-style half mix.
  assign in_x     = in_data ^ in_key[127:64];
  assign in_white = {in_x[63:32], in_x[63:32] ^ in_x[31:0]};

  // Inverse half mix of the final round result, then output whitening with the low key quarter.
  assign out_white = {rnd_odata[63:32], rnd_odata[31:0] ^ rnd_odata[63:32]} ^ key_q[63:0];

  // Round keys are consumed MSB-first: k0 = key_q[255 -: RK_W] on the first round.
  assign key_shamt = 8'(rnd_cnt_q) * 8'(RK_W);
  assign key_msb   = 8'd255 - key_shamt;
  assign rnd_key   = key_q[key_msb -: RK_W];
  assign rnd_idata = state_q;

  assign busy      = (fsm_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state logic: flush beats accept, accept beats the per-state progression.
  always_comb begin
    fsm_d       = fsm_q;
    rnd_cnt_d   = rnd_cnt_q;
    state_d     = state_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (flush) begin
      fsm_d       = IDLE;
      out_valid_d = 1'b0;
      rnd_cnt_d   = 4'd0;
    end else if (accept) begin
      key_d       = in_key;
      state_d     = in_white;
      rnd_cnt_d   = 4'd0;
      out_valid_d = 1'b0;
      fsm_d       = ROUND;
    end else begin
      case (fsm_q)
        ROUND: begin
          state_d = rnd_odata;
          if (rnd_cnt_q == LAST_RND) begin
            // Last pass: capture the unwhitened result directly from the round unit.
            out_data_d  = out_white;
            out_valid_d = 1'b1;
            rnd_cnt_d   = 4'd0;
            fsm_d       = OUT;
          end else begin
            rnd_cnt_d = rnd_cnt_q + 4'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            fsm_d       = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers; reset clears everything so no partial result is ever visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_cnt_q   <= 4'd0;
      state_q     <= 64'd0;
      key_q       <= 256'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
    end else begin
      fsm_q       <= fsm_d;
      rnd_cnt_q   <= rnd_cnt_d;
      state_q     <= state_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_cipher_round_seq.sv
// Self-checking bench for cipher_round_seq with a behavioural reference model.
// The round unit is a bench-side stub: identity, or a keyed rotate/xor mix.
// Summary line reports comparisons made and failed.
module tb_cipher_round_seq;

  localparam int NR = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic [255:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic         flush = 1'b0;
  logic         busy;
  logic [63:0]  rnd_idata;
  logic [15:0]  rnd_key;
  logic [63:0]  rnd_odata;
  bit           stub_mode = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] stub_f(input logic [63:0] d, input logic [15:0] k);
    return {d[50:0], d[63:51]} ^ {k, 32'h0, k} ^ 64'h0123_4567_89ab_cdef;
  endfunction

  assign rnd_odata = stub_mode ? stub_f(rnd_idata, rnd_key) : rnd_idata;

  cipher_round_seq #(.NROUNDS(NR), .RK_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .busy(busy),
    .rnd_idata(rnd_idata), .rnd_key(rnd_key), .rnd_odata(rnd_odata)
  );

  // Reference: whiten, apply NR stub rounds with keys taken MSB-first, unwhiten.
  function automatic logic [63:0] ref_cipher(input logic [63:0] d, input logic [255:0] k, input bit mode);
    logic [63:0] x, s;
    logic [15:0] rk;
    x = d ^ k[127:64];
    s = {x[63:32], x[63:32] ^ x[31:0]};
    for (int i = 0; i < NR; i++) begin
      rk = 16'(k >> (240 - 16 * i));
      if (mode) s = stub_f(s, rk);
    end
    return {s[63:32], s[31:0] ^ s[63:32]} ^ k[63:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a block and hold it until accepted; returns at 1 time unit after the accept edge.
  task automatic accept(input logic [63:0] d, input logic [255:0] k, output bit ok);
    int n;
    n = 0;
    in_data = d; in_key = k; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin step(); n++; end
    ok = in_ready;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin step(); cyc++; end
  endtask

  task automatic test_reset();
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    tests++; if (out_data !== 64'd0) begin fails++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    step();
  endtask

  task automatic test_single();
    bit ok; int cyc;
    stub_mode = 1'b0; out_ready = 1'b1;
    accept(64'h00000001_00000000, 256'd0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_accept timeout"); end
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL single_in_ready_round cyc=%0d got=%b want=0", cyc, in_ready); end
      step(); cyc++;
    end
    tests++; if (cyc != NR) begin fails++; $display("FAIL single_latency got=%0d want=%0d", cyc, NR); end
    tests++; if (out_data !== 64'h00000001_00000000) begin fails++; $display("FAIL single_data got=%h want=%h", out_data, 64'h00000001_00000000); end
    step();
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL single_drain busy=%b out_valid=%b want 0/0", busy, out_valid); end
  endtask

  task automatic test_key_order();
    bit ok; int cyc;
    logic [255:0] k;
    stub_mode = 1'b0; out_ready = 1'b1;
    k = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010;
    accept(rand64(), k, ok);
    tests++; if (!ok) begin fails++; $display("FAIL keyorder_accept timeout"); end
    for (int i = 0; i < NR; i++) begin
      tests++;
      if (rnd_key !== 16'(i + 1)) begin fails++; $display("FAIL keyorder_rk%0d got=%h want=%h", i, rnd_key, 16'(i + 1)); end
      step();
    end
    wait_out(cyc);
    tests++; if (cyc != 0) begin fails++; $display("FAIL keyorder_valid_after_last got_extra=%0d want=0", cyc); end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc;
    logic [63:0] d1, d2; logic [255:0] k1, k2;
    stub_mode = 1'b1; out_ready = 1'b0;
    d1 = rand64(); k1 = rand256(); d2 = rand64(); k2 = rand256();
    accept(d1, k1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_accept1 timeout"); end
    wait_out(cyc);
    tests++; if (cyc != NR) begin fails++; $display("FAIL b2b_latency1 got=%0d want=%0d", cyc, NR); end
    tests++; if (out_data !== ref_cipher(d1, k1, 1'b1)) begin fails++; $display("FAIL b2b_data1 got=%h want=%h", out_data, ref_cipher(d1, k1, 1'b1)); end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_data !== ref_cipher(d1, k1, 1'b1)) begin
        fails++; $display("FAIL b2b_hold%0d valid=%b data=%h want 1/%h", i, out_valid, out_data, ref_cipher(d1, k1, 1'b1));
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = d2; in_key = k2;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_same_cycle_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_after_handoff valid=%b busy=%b want 0/1", out_valid, busy); end
    wait_out(cyc);
    tests++; if (cyc != NR) begin fails++; $display("FAIL b2b_latency2 got=%0d want=%0d", cyc, NR); end
    tests++; if (out_data !== ref_cipher(d2, k2, 1'b1)) begin fails++; $display("FAIL b2b_data2 got=%h want=%h", out_data, ref_cipher(d2, k2, 1'b1)); end
    step();
  endtask

  task automatic test_key_stability();
    bit ok; int cyc;
    logic [63:0] d; logic [255:0] k;
    stub_mode = 1'b1; out_ready = 1'b1;
    d = rand64(); k = rand256();
    accept(d, k, ok);
    tests++; if (!ok) begin fails++; $display("FAIL keystab_accept timeout"); end
    step(); step(); step();
    in_key = '1;
    wait_out(cyc);
    tests++; if (out_data !== ref_cipher(d, k, 1'b1)) begin fails++; $display("FAIL keystab_data got=%h want=%h", out_data, ref_cipher(d, k, 1'b1)); end
    step();
  endtask

  task automatic test_flush();
    bit ok, rose; int cyc;
    logic [63:0] d; logic [255:0] k;
    stub_mode = 1'b1; out_ready = 1'b1;
    accept(rand64(), rand256(), ok);
    tests++; if (!ok) begin fails++; $display("FAIL flush_accept timeout"); end
    step(); step(); step();
    flush = 1'b1; in_valid = 1'b1; in_data = rand64(); in_key = rand256();
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_idle busy=%b valid=%b want 0/0", busy, out_valid); end
    rose = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) rose = 1'b1;
      step();
    end
    tests++; if (rose) begin fails++; $display("FAIL flush_no_output got=1 want=0"); end
    d = rand64(); k = rand256();
    accept(d, k, ok);
    tests++; if (!ok) begin fails++; $display("FAIL flush_reaccept timeout"); end
    wait_out(cyc);
    tests++; if (cyc != NR) begin fails++; $display("FAIL flush_post_latency got=%0d want=%0d", cyc, NR); end
    tests++; if (out_data !== ref_cipher(d, k, 1'b1)) begin fails++; $display("FAIL flush_post_data got=%h want=%h", out_data, ref_cipher(d, k, 1'b1)); end
    step();
  endtask

  task automatic test_async_reset();
    bit ok, rose; int cyc;
    stub_mode = 1'b1; out_ready = 1'b1;
    accept(rand64(), rand256(), ok);
    tests++; if (!ok) begin fails++; $display("FAIL arst_accept timeout"); end
    step(); step();
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL arst_round valid=%b busy=%b in_ready=%b want 0/0/0", out_valid, busy, in_ready);
    end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL arst_release in_ready=%b busy=%b want 1/0", in_ready, busy); end
    rose = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0) rose = 1'b1;
    end
    tests++; if (rose) begin fails++; $display("FAIL arst_no_output got=1 want=0"); end
    out_ready = 1'b0;
    accept(rand64(), rand256(), ok);
    tests++; if (!ok) begin fails++; $display("FAIL arst_accept2 timeout"); end
    wait_out(cyc);
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin fails++; $display("FAIL arst_out valid=%b data=%h want 0/0", out_valid, out_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    logic [63:0] d, e;
    logic [255:0] k;
    int sent, got, cyc;
    bit acc;
    stub_mode = 1'b1; in_valid = 1'b0;
    sent = 0; got = 0; cyc = 0;
    d = '0; k = '0;
    while ((sent < 20 || got < 20) && cyc < 4000) begin
      if (!in_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
        d = rand64(); k = rand256();
        in_data = d; in_key = k; in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (acc) begin exp_q.push_back(ref_cipher(d, k, 1'b1)); sent++; end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rand_unexpected_out got=%h want=none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin fails++; $display("FAIL rand_data%0d got=%h want=%h", got, out_data, e); end
        end
        got++;
      end
      step();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    tests++; if (got != 20) begin fails++; $display("FAIL rand_count got=%0d want=20", got); end
    out_ready = 1'b1;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_key_order();
    test_back_to_back();
    test_key_stability();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cipher_round_seq.md
Name: cipher_round_seq

Overview:
- Iterative sequencer for the 64-bit / 256-bit-key block cipher.
- Owns one externally instantiated round unit (combinational, 64-bit data plus 16-bit round key, output valid in the same cycle) and time-multiplexes it over NROUNDS cycles.
- Performs input whitening and output whitening around the rounds.
- Exposes valid/ready streaming interfaces so the cipher can sit between a block source and sink without a fully unrolled datapath.

Parameters:
- NROUNDS, 8, number of round-unit passes per block; legal range 1..16.
- RK_W, 16, round-key width; fixed, key must supply NROUNDS*RK_W <= 256 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  block/key offered.
- in_ready  out  1  sequencer can accept.
- in_data  in  64  plaintext block.
- in_key  in  256  cipher key, k0..kf from MSB to LSB.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  sink accepts.
- out_data  out  64  ciphertext.
- flush  in  1  synchronous abort of the block in flight.
- busy  out  1  high in any state except IDLE.
- rnd_idata  out  64  data presented to the round unit.
- rnd_key  out  16  round key presented to the round unit.
- rnd_odata  in  64  round unit result, combinational from rnd_idata/rnd_key.

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, rnd_cnt=0, state_q=0, key_q=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=0 while rst is high, 1 after release.
- States: IDLE, ROUND, OUT.
- Accept = in_valid & in_ready.
- in_ready = (state==IDLE) | (state==OUT & out_ready); this allows back-to-back blocks.
- On accept:
  - key_q <= in_key.
  - x = in_data ^ in_key[127:64].
  - state_q <= {x[63:32], x[63:32]^x[31:0]}.
  - rnd_cnt <= 0, go to ROUND.
- Round-unit drive:
  - rnd_idata = state_q.
  - rnd_key = key_q[255-16*rnd_cnt -: 16].
  - In IDLE/OUT both outputs are held at state_q/key_q-derived values; their value is don't-care to the sink.
- ROUND, each cycle:
  - state_q <= rnd_odata, rnd_cnt++.
  - When rnd_cnt==NROUNDS-1, that same edge computes y=rnd_odata.
  - out_data <= {y[63:32], y[31:0]^y[63:32]} ^ key_q[63:0].
  - out_valid <= 1, go to OUT.
- Latency: accept edge E0, round i applied at edge E(i+1); out_valid rises after edge E(NROUNDS), i.e. 8 cycles for the default.
- OUT:
  - out_data/out_valid held stable until out_ready=1.
  - On out_ready: if in_valid the same cycle, the accept path executes (go to ROUND, out_valid<=0); else go to IDLE, out_valid<=0.
- key_q is captured only on accept; changes on in_key mid-block have no effect.
- flush=1 (any state, priority over all else): next edge state=IDLE, out_valid=0, rnd_cnt=0. A simultaneous accept is ignored; in_ready is forced 0 while flush=1.
- rst asserted mid-block: immediate return to reset values; no partial output is ever presented.
- busy = (state!=IDLE).
- rnd_cnt width 4 bits; it never wraps past NROUNDS-1.

Test Plan:
- Bench uses a round stub with rnd_odata=rnd_idata.
- Single block: key=0, in_data=64'h00000001_00000000, out_ready=1 -> out_valid exactly 8 cycles after accept, out_data=64'h00000001_00000000, in_ready low during ROUND.
- Round-key order:
  - Stub logs rnd_key; in_key=256'h0001_0002_..._000f_0010 (k0=1..kf=16), NROUNDS=8.
  - Required: rnd_key sequence 1,2,3,4,5,6,7,8 on consecutive ROUND cycles.
- Backpressure + back-to-back:
  - out_ready=0 for 5 cycles after out_valid -> out_data stable.
  - Raise out_ready with in_valid=1 -> same-cycle accept.
  - Second result arrives 8 cycles later; no bubble beyond spec.
- Key stability: change in_key to all-ones 3 cycles into ROUND -> output equals the value computed with the originally captured key.
- Flush: assert flush in round 4 -> out_valid never rises; busy=0 next cycle; a new block accepted afterward completes correctly.
- Async reset: pulse rst between edges during ROUND -> out_valid=0 and busy=0 immediately; in_ready=1 after release.
